// File: rtl/display_buffer_ring.sv
// display_buffer_ring: multi-buffer frame store between renderer (port b) and
// scan-out (port a). Double or triple buffering with frame-synchronised swaps
// and an optional hardware clear of each newly assigned render buffer.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | render buffer usable, port b writes accepted
// ST_CLEAR | walking render buffer writing CLEAR_VALUE, port b writes dropped
module display_buffer_ring #(
    parameter int                   PIXEL_W       = 24,
    parameter int                   ADDR_X_W      = 10,
    parameter int                   ADDR_Y_W      = 9,
    parameter int                   TRIPLE        = 1,
    parameter int                   CLEAR_ON_SWAP = 1,
    parameter logic [PIXEL_W-1:0]   CLEAR_VALUE   = '0,
    parameter int                   CNT_W         = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ADDR_X_W-1:0] address_a_x,
    input  logic [ADDR_Y_W-1:0] address_a_y,
    output logic [PIXEL_W-1:0]  data_a,
    input  logic [ADDR_X_W-1:0] address_b_x,
    input  logic [ADDR_Y_W-1:0] address_b_y,
    input  logic                write_enable_b,
    input  logic [PIXEL_W-1:0]  write_data_b,
    output logic [PIXEL_W-1:0]  data_b,
    input  logic                swap_request,
    input  logic                frame_complete,
    output logic                busy_b,
    output logic [1:0]          display_index,
    output logic [1:0]          render_index,
    output logic [CNT_W-1:0]    dropped_frames
);

    localparam int NBUF  = 2 + TRIPLE;
    localparam int AW    = ADDR_X_W + ADDR_Y_W;
    localparam int DEPTH = 1 << AW;
    // Buffer-select width: one bit suffices for two buffers.
    localparam int BW    = (NBUF > 2) ? 2 : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [PIXEL_W-1:0] mem [NBUF][DEPTH];

    logic [1:0]    d_q, r_q, w_q;
    logic [1:0]    d_nxt, r_nxt, w_nxt;
    // Triple mode: a finished frame waits in R. Double mode: a swap is pending.
    logic          flag_q, flag_nxt;
    logic          drop_inc;
    logic          swap_ok;
    logic [0:0]    state_q;
    logic [AW-1:0] clr_addr_q;
    logic [AW-1:0] addr_a, addr_b;
    logic [BW-1:0] d_sel, w_sel;

    assign addr_a         = {address_a_y, address_a_x};
    assign addr_b         = {address_b_y, address_b_x};
    assign d_sel          = d_q[BW-1:0];
    assign w_sel          = w_q[BW-1:0];
    assign busy_b         = (state_q == ST_CLEAR);
    assign swap_ok        = swap_request && !busy_b;
    assign display_index  = d_q;
    assign render_index   = w_q;

    // Next buffer assignment: renderer swap is applied first, then the
    // display's frame boundary sees the result of that swap.
    always_comb begin
        d_nxt    = d_q;
        r_nxt    = r_q;
        w_nxt    = w_q;
        flag_nxt = flag_q;
        drop_inc = 1'b0;
        if (swap_ok) begin
            drop_inc = flag_q;
            flag_nxt = 1'b1;
            if (TRIPLE != 0) begin
                w_nxt = r_q;
                r_nxt = w_q;
            end
        end
        if (frame_complete && flag_nxt) begin
            flag_nxt = 1'b0;
            if (TRIPLE != 0) begin
                d_nxt = r_nxt;
                r_nxt = d_q;
            end else begin
                d_nxt = w_q;
                w_nxt = d_q;
            end
        end
    end

    // Buffer indices, ready/pending flag and saturating drop counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            d_q            <= 2'd0;
            w_q            <= 2'd1;
            r_q            <= 2'd2;
            flag_q         <= 1'b0;
            dropped_frames <= '0;
        end else begin
            d_q    <= d_nxt;
            w_q    <= w_nxt;
            r_q    <= r_nxt;
            flag_q <= flag_nxt;
            if (drop_inc && (dropped_frames != '1))
                dropped_frames <= dropped_frames + 1'b1;
        end
    end

    // Clear sequencer: any new render buffer is wiped one address per cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            clr_addr_q <= '0;
        end else if ((CLEAR_ON_SWAP != 0) && (w_nxt != w_q)) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
        end else if (state_q == ST_CLEAR) begin
            if (clr_addr_q == '1)
                state_q <= ST_IDLE;
            clr_addr_q <= clr_addr_q + 1'b1;
        end
    end

    // Buffer writes: clear traffic owns port b while busy.
    always_ff @(posedge clock) begin
        if (state_q == ST_CLEAR)
            mem[w_sel][clr_addr_q] <= CLEAR_VALUE;
        else if (write_enable_b)
            mem[w_sel][addr_b] <= write_data_b;
    end

    // Registered read ports; port b reads old data on a same-address write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_a <= '0;
            data_b <= '0;
        end else begin
            data_a <= mem[d_sel][addr_a];
            data_b <= mem[w_sel][addr_b];
        end
    end

endmodule

// File: tb/tb_display_buffer_ring.sv
// Directed bench for display_buffer_ring: one triple-buffered instance with
// clear and a 2-bit drop counter, one double-buffered instance without clear.
module tb_display_buffer_ring;

    logic       clock = 1'b0;
    logic       reset = 1'b1;

    // triple-buffer instance
    logic [1:0] ax, bx;
    logic       ay, by;
    logic       we, swap, fc;
    logic [7:0] wdata, da, db;
    logic       busy;
    logic [1:0] didx, ridx;
    logic [1:0] dropped;

    // double-buffer instance
    logic [1:0] d_ax, d_bx;
    logic       d_ay, d_by;
    logic       d_we, d_swap, d_fc;
    logic [7:0] d_wdata, d_da, d_db;
    logic       d_busy;
    logic [1:0] d_didx, d_ridx;
    logic [3:0] d_dropped;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    display_buffer_ring #(
        .PIXEL_W(8), .ADDR_X_W(2), .ADDR_Y_W(1), .TRIPLE(1),
        .CLEAR_ON_SWAP(1), .CLEAR_VALUE(8'h00), .CNT_W(2)
    ) u_t (
        .clock(clock), .reset(reset),
        .address_a_x(ax), .address_a_y(ay), .data_a(da),
        .address_b_x(bx), .address_b_y(by),
        .write_enable_b(we), .write_data_b(wdata), .data_b(db),
        .swap_request(swap), .frame_complete(fc), .busy_b(busy),
        .display_index(didx), .render_index(ridx), .dropped_frames(dropped)
    );

    display_buffer_ring #(
        .PIXEL_W(8), .ADDR_X_W(2), .ADDR_Y_W(1), .TRIPLE(0),
        .CLEAR_ON_SWAP(0), .CLEAR_VALUE(8'h00), .CNT_W(4)
    ) u_d (
        .clock(clock), .reset(reset),
        .address_a_x(d_ax), .address_a_y(d_ay), .data_a(d_da),
        .address_b_x(d_bx), .address_b_y(d_by),
        .write_enable_b(d_we), .write_data_b(d_wdata), .data_b(d_db),
        .swap_request(d_swap), .frame_complete(d_fc), .busy_b(d_busy),
        .display_index(d_didx), .render_index(d_ridx), .dropped_frames(d_dropped)
    );

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("clear_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        ax = 0; ay = 0; bx = 0; by = 0; we = 0; swap = 0; fc = 0; wdata = 0;
        d_ax = 0; d_ay = 0; d_bx = 0; d_by = 0; d_we = 0; d_swap = 0; d_fc = 0; d_wdata = 0;
        tick(); tick();

        // reset values
        chk("rst_disp", {30'd0, didx}, 32'd0);
        chk("rst_rend", {30'd0, ridx}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_drop", {30'd0, dropped}, 32'd0);
        chk("rst_da", {24'd0, da}, 32'd0);
        chk("rst_db", {24'd0, db}, 32'd0);
        reset = 0;
        tick();

        // ---- double mode ----
        d_fc = 1; tick(); d_fc = 0;
        chk("dbl_fc_alone_d", {30'd0, d_didx}, 32'd0);
        chk("dbl_fc_alone_w", {30'd0, d_ridx}, 32'd1);
        d_we = 1; d_bx = 2; d_by = 1; d_wdata = 8'h77; tick(); d_we = 0;
        d_swap = 1; tick(); d_swap = 0;
        chk("dbl_pending_d", {30'd0, d_didx}, 32'd0);
        d_fc = 1; tick(); d_fc = 0;
        chk("dbl_swap_d", {30'd0, d_didx}, 32'd1);
        chk("dbl_swap_w", {30'd0, d_ridx}, 32'd0);
        d_ax = 2; d_ay = 1; tick();
        chk("dbl_data_a", {24'd0, d_da}, 32'h77);
        d_swap = 1; tick(); tick(); d_swap = 0;
        chk("dbl_drop", {28'd0, d_dropped}, 32'd1);
        chk("dbl_drop_d", {30'd0, d_didx}, 32'd1);
        d_fc = 1; tick(); d_fc = 0;
        chk("dbl_swap2_d", {30'd0, d_didx}, 32'd0);
        d_swap = 1; d_fc = 1; tick(); d_swap = 0; d_fc = 0;
        chk("dbl_same_d", {30'd0, d_didx}, 32'd1);
        chk("dbl_same_w", {30'd0, d_ridx}, 32'd0);
        chk("dbl_same_drop", {28'd0, d_dropped}, 32'd1);
        chk("dbl_busy", {31'd0, d_busy}, 32'd0);

        // ---- triple mode: writes and read-first ----
        we = 1; bx = 1; by = 0; wdata = 8'h5A; tick();
        wdata = 8'hA5; tick();
        chk("read_first", {24'd0, db}, 32'h5A);
        we = 0; tick();
        chk("read_back", {24'd0, db}, 32'hA5);

        // swap starts clear of buffer 2; a write during clear is dropped
        swap = 1; tick(); swap = 0;
        chk("swap_rend", {30'd0, ridx}, 32'd2);
        chk("swap_disp", {30'd0, didx}, 32'd0);
        chk("swap_busy", {31'd0, busy}, 32'd1);
        begin
            int cnt = 0;
            we = 1; bx = 0; by = 0; wdata = 8'h3C;
            while (busy === 1'b1 && cnt < 20) begin
                cnt++;
                tick();
                we = 0;
            end
            chk("busy_len", cnt, 32'd8);
        end
        tick();
        chk("busy_write_dropped", {24'd0, db}, 32'h00);

        // frame boundary exposes the finished frame
        ax = 1; ay = 0; fc = 1; tick(); fc = 0;
        chk("fc_disp", {30'd0, didx}, 32'd1);
        chk("fc_rend", {30'd0, ridx}, 32'd2);
        tick();
        chk("fc_data_a", {24'd0, da}, 32'hA5);

        // two swaps without a frame boundary drop one frame
        swap = 1; tick(); swap = 0;
        chk("swap3_rend", {30'd0, ridx}, 32'd0);
        wait_idle();
        swap = 1; tick(); swap = 0;
        chk("drop1", {30'd0, dropped}, 32'd1);
        chk("drop1_disp", {30'd0, didx}, 32'd1);
        chk("drop1_rend", {30'd0, ridx}, 32'd2);

        // swap while busy is ignored
        swap = 1; tick(); swap = 0;
        chk("busy_swap_rend", {30'd0, ridx}, 32'd2);
        chk("busy_swap_drop", {30'd0, dropped}, 32'd1);
        wait_idle();

        // reset in the middle of a clear
        swap = 1; tick(); swap = 0;
        tick(); tick();
        reset = 1; tick();
        chk("mid_rst_disp", {30'd0, didx}, 32'd0);
        chk("mid_rst_rend", {30'd0, ridx}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_drop", {30'd0, dropped}, 32'd0);
        chk("mid_rst_da", {24'd0, da}, 32'd0);
        chk("mid_rst_db", {24'd0, db}, 32'd0);
        reset = 0; tick();
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        // same-cycle swap and frame boundary from D=0 R=2 W=1
        swap = 1; fc = 1; tick(); swap = 0; fc = 0;
        chk("same_disp", {30'd0, didx}, 32'd1);
        chk("same_rend", {30'd0, ridx}, 32'd2);
        chk("same_drop", {30'd0, dropped}, 32'd0);
        wait_idle();
        fc = 1; tick(); fc = 0;
        chk("same_rv_clear", {30'd0, didx}, 32'd1);
        swap = 1; tick(); swap = 0;
        chk("same_next_drop", {30'd0, dropped}, 32'd0);
        chk("same_next_rend", {30'd0, ridx}, 32'd0);
        wait_idle();

        // drop counter saturates at all-ones
        for (int i = 0; i < 4; i++) begin
            swap = 1; tick(); swap = 0;
            chk("sat_drop", {30'd0, dropped}, (i < 3) ? i + 1 : 3);
            wait_idle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_buffer_ring.md
# display_buffer_ring

Parametrised multi-buffer frame store between the renderer (port b) and the VGA scan-out (port a), successor to the fixed two-buffer display mux. Supports double or triple buffering, arbitrary pixel and address widths, renderer-initiated swap requests synchronised to the display's frame boundary, and an optional hardware clear of each newly assigned render buffer. Sits between the rasteriser write path and the video timing generator.

## Interface
- PIXEL_W, 24, pixel width in bits
- ADDR_X_W, 10, x address width; buffer row length 2^ADDR_X_W
- ADDR_Y_W, 9, y address width; row count 2^ADDR_Y_W
- TRIPLE, 1, 0 = double buffering, 1 = triple buffering
- CLEAR_ON_SWAP, 1, 1 = clear each buffer on assignment as render buffer
- CLEAR_VALUE, 0, PIXEL_W-bit value written during clear
- CNT_W, 16, width of dropped_frames

Ports (reset reset, asynchronous, active-high; clock clock):
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- address_a_x / address_a_y  in  ADDR_X_W / ADDR_Y_W  scan-out read address
- data_a  out  PIXEL_W  display-buffer pixel, registered
- address_b_x / address_b_y  in  ADDR_X_W / ADDR_Y_W  renderer address
- write_enable_b  in  1  write write_data_b to render buffer
- write_data_b  in  PIXEL_W  renderer pixel
- data_b  out  PIXEL_W  render-buffer pixel, registered
- swap_request  in  1  one-cycle pulse: renderer finished current frame
- frame_complete  in  1  one-cycle pulse: display finished scanning a frame
- busy_b  out  1  clear in progress; port b writes dropped
- display_index / render_index  out  2  buffer currently on port a / port b
- dropped_frames  out  CNT_W  count of completed frames discarded unseen; saturates

## Operation
- Buffers: 2+TRIPLE arrays, each 2^(ADDR_X_W+ADDR_Y_W) entries, address {y,x}.
- Triple mode: indices D (display), R (ready), W (render) always a permutation of {0,1,2}; flag ready_valid.
  - swap_request (busy_b=0): swap W and R, ready_valid<=1; if ready_valid already 1, dropped_frames++.
  - frame_complete with ready_valid=1: swap D and R, ready_valid<=0. With ready_valid=0: no change.
  - Same cycle: swap applied first, then frame_complete; net new D = old W, new W = old R, R = old D, ready_valid=0; dropped_frames++ if old ready_valid=1.
- Double mode: indices D, W; flag pending.
  - swap_request (busy_b=0): pending<=1; if pending already 1, dropped_frames++.
  - frame_complete with pending=1 (or swap_request same cycle): swap D and W, pending<=0.
- swap_request while busy_b=1: ignored entirely, no counter change.
- Clear FSM (CLEAR_ON_SWAP=1), states IDLE, CLEAR. Any change of render_index → CLEAR; counter walks addresses 0..2^(ADDR_X_W+ADDR_Y_W)-1 writing CLEAR_VALUE into new W, one per cycle; after last address → IDLE. busy_b=1 exactly while in CLEAR. Port b writes during CLEAR discarded. If render_index changes again during CLEAR (triple, frame_complete cannot alter W; only swap_request, which is ignored) — no restart case exists.
- CLEAR_ON_SWAP=0: FSM held in IDLE, busy_b=0.
- dropped_frames saturates at all-ones.
- Reset: D=0, W=1, R=2 (triple), ready_valid=0, pending=0, FSM IDLE, busy_b=0, dropped_frames=0, data_a=0, data_b=0. No clear after reset; memory contents unchanged by reset. Reset mid-clear aborts clear immediately.

## Timing
- data_a / data_b: 1-cycle latency; value is buffer contents addressed in cycle n, from buffer selected in cycle n, valid after edge n+1.
- Port b read-first: write and read same address same cycle returns old data.
- Index/flag updates take effect at the edge sampling the event; reads in the following cycle use new indices.
- busy_b rises at the same edge render_index changes; clear takes 2^(ADDR_X_W+ADDR_Y_W) cycles; busy_b falls at the edge after the last clear write; port b write accepted that cycle.

## Test plan
- Reset: assert mid-operation → indices 0/1(/2), busy_b=0, dropped_frames=0, data_a=data_b=0 next cycle.
- Triple, ADDR_X_W=2, ADDR_Y_W=1, CLEAR_ON_SWAP=1: write 0xA5 at (1,0), swap_request → render_index=2, busy_b high 8 cycles; frame_complete → display_index=1, data_a at (1,0)=0xA5.
- Two swap_requests without frame_complete (after clears) → dropped_frames=1, display_index unchanged.
- Same-cycle swap_request and frame_complete from D=0,R=2,W=1 → display_index=1, render_index=2, ready_valid=0.
- Write during busy_b=1 at (0,0) value 0x3C → reads back CLEAR_VALUE after clear.
- Double mode: swap_request then frame_complete → indices swap; frame_complete alone → no change.
